// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data main-memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } gnt_e;

    // Instruction fetches are always full-word reads.
    localparam logic [2:0] FETCH_SIZE = 3'b010;

endpackage

// File: rtl/mem_arbiter.sv
// Serialises fetch and data-stage requests onto one single-port memory.
// Data wins ties, but a bounded streak counter guarantees fetch progress.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  IReqF,
    input  logic [ADDR_WIDTH-1:0] IAddrF,
    output logic [DATA_WIDTH-1:0] IRdataF,
    output logic                  IReadyF,
    input  logic                  DReqM,
    input  logic                  DWeM,
    input  logic [ADDR_WIDTH-1:0] DAddrM,
    input  logic [DATA_WIDTH-1:0] DWdataM,
    input  logic [2:0]            DSizeM,
    output logic [DATA_WIDTH-1:0] DRdataM,
    output logic                  DReadyM,
    output logic                  MemReq,
    output logic                  MemWe,
    output logic [ADDR_WIDTH-1:0] MemAddr,
    output logic [DATA_WIDTH-1:0] MemWdata,
    output logic [2:0]            MemSize,
    input  logic [DATA_WIDTH-1:0] MemRdata,
    input  logic                  MemReady
);

    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    state_e                state_q,  state_d;
    gnt_e                  gnt_q,    gnt_d;
    logic [SW-1:0]         streak_q, streak_d;
    logic                  we_q,     we_d;
    logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
    logic [DATA_WIDTH-1:0] wdata_q,  wdata_d;
    logic [2:0]            size_q,   size_d;
    logic [DATA_WIDTH-1:0] irdata_q, irdata_d;
    logic [DATA_WIDTH-1:0] drdata_q, drdata_d;

    logic d_wins;

    // Data wins unless a fetch is waiting and data has used up its streak.
    assign d_wins = DReqM && !(IReqF && (streak_q == STREAK_MAX));

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        streak_d = streak_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        size_d   = size_q;
        irdata_d = irdata_q;
        drdata_d = drdata_q;
        case (state_q)
            IDLE: begin
                if (IReqF || DReqM) begin
                    state_d = BUSY;
                    if (d_wins) begin
                        gnt_d   = GNT_D;
                        we_d    = DWeM;
                        addr_d  = DAddrM;
                        wdata_d = DWdataM;
                        size_d  = DSizeM;
                        if (!IReqF) begin
                            streak_d = '0;
                        end else if (streak_q != STREAK_MAX) begin
                            streak_d = streak_q + 1'b1;
                        end
                    end else begin
                        gnt_d    = GNT_I;
                        we_d     = 1'b0;
                        addr_d   = IAddrF;
                        wdata_d  = '0;
                        size_d   = FETCH_SIZE;
                        streak_d = '0;
                    end
                end
            end
            BUSY: begin
                if (MemReady) begin
                    state_d = RESP;
                    if (!we_q) begin
                        if (gnt_q == GNT_I) begin
                            irdata_d = MemRdata;
                        end else begin
                            drdata_d = MemRdata;
                        end
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            gnt_q    <= GNT_I;
            streak_q <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            size_q   <= '0;
            irdata_q <= '0;
            drdata_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            streak_q <= streak_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            size_q   <= size_d;
            irdata_q <= irdata_d;
            drdata_q <= drdata_d;
        end
    end

    assign MemReq   = (state_q == BUSY);
    assign MemWe    = we_q;
    assign MemAddr  = addr_q;
    assign MemWdata = wdata_q;
    assign MemSize  = size_q;
    assign IReadyF  = (state_q == RESP) && (gnt_q == GNT_I);
    assign DReadyM  = (state_q == RESP) && (gnt_q == GNT_D);
    assign IRdataF  = irdata_q;
    assign DRdataM  = drdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table of single transactions plus
// hand-written sequences for arbitration, streak, mid-BUSY changes and reset.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        IReqF;
    logic [31:0] IAddrF;
    logic [31:0] IRdataF;
    logic        IReadyF;
    logic        DReqM;
    logic        DWeM;
    logic [31:0] DAddrM;
    logic [31:0] DWdataM;
    logic [2:0]  DSizeM;
    logic [31:0] DRdataM;
    logic        DReadyM;
    logic        MemReq;
    logic        MemWe;
    logic [31:0] MemAddr;
    logic [31:0] MemWdata;
    logic [2:0]  MemSize;
    logic [31:0] MemRdata;
    logic        MemReady;

    int n_cmp = 0;
    int n_mis = 0;
    logic perturb = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .MAX_D_STREAK(4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .IReqF   (IReqF),
        .IAddrF  (IAddrF),
        .IRdataF (IRdataF),
        .IReadyF (IReadyF),
        .DReqM   (DReqM),
        .DWeM    (DWeM),
        .DAddrM  (DAddrM),
        .DWdataM (DWdataM),
        .DSizeM  (DSizeM),
        .DRdataM (DRdataM),
        .DReadyM (DReadyM),
        .MemReq  (MemReq),
        .MemWe   (MemWe),
        .MemAddr (MemAddr),
        .MemWdata(MemWdata),
        .MemSize (MemSize),
        .MemRdata(MemRdata),
        .MemReady(MemReady)
    );

    typedef struct {
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwe;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic [2:0]  dsize;
        int          waits;
        logic [31:0] mrdata;
        logic        exp_d;
        logic [31:0] exp_addr;
        logic        exp_we;
        logic [2:0]  exp_size;
        logic [31:0] exp_wdata;
        logic [31:0] exp_irdata;
        logic [31:0] exp_drdata;
    } vec_t;

    typedef struct {
        int          lat;
        logic        ri;
        logic        rd;
        logic        we;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obs_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    // Precondition: at a negedge with requests driven. Returns at the RESP negedge.
    task automatic serve(input int waits, input logic [31:0] rdata, output obs_t o);
        o = '{lat: 0, ri: 1'b0, rd: 1'b0, we: 1'b0, size: 3'b0, addr: 32'h0, wdata: 32'h0};
        @(posedge clk); @(negedge clk);
        while (!MemReq && o.lat < 8) begin
            o.lat++;
            @(posedge clk); @(negedge clk);
        end
        chk("grant_seen", 32'(MemReq), 32'd1);
        if (!MemReq) return;
        o.addr  = MemAddr;
        o.wdata = MemWdata;
        o.we    = MemWe;
        o.size  = MemSize;
        for (int w = 0; w < waits; w++) begin
            chk("busy_noready", 32'({IReadyF, DReadyM}), 32'd0);
            if (perturb) begin
                DAddrM  = ~DAddrM;
                IAddrF  = ~IAddrF;
                DWdataM = ~DWdataM;
                DWeM    = ~DWeM;
            end
            @(posedge clk); @(negedge clk);
            chk("busy_req", 32'(MemReq), 32'd1);
            chk("busy_addr", MemAddr, o.addr);
            chk("busy_wdata", MemWdata, o.wdata);
            chk("busy_we", 32'(MemWe), 32'(o.we));
        end
        MemReady = 1'b1;
        MemRdata = rdata;
        @(posedge clk); @(negedge clk);
        MemReady = 1'b0;
        MemRdata = 32'h0;
        o.ri = IReadyF;
        o.rd = DReadyM;
        chk("resp_memreq", 32'(MemReq), 32'd0);
        chk("one_ready", 32'(IReadyF & DReadyM), 32'd0);
    endtask

    task automatic drop_and_idle();
        IReqF = 1'b0;
        DReqM = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("pulse_end", 32'({IReadyF, DReadyM}), 32'd0);
        chk("idle_memreq", 32'(MemReq), 32'd0);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        obs_t o;
        IReqF = v.ireq;  IAddrF = v.iaddr;
        DReqM = v.dreq;  DWeM = v.dwe;  DAddrM = v.daddr;
        DWdataM = v.dwdata;  DSizeM = v.dsize;
        serve(v.waits, v.mrdata, o);
        $display("vec %0d: addr=%h we=%0d size=%0d ri=%0d rd=%0d irdata=%h drdata=%h",
                 idx, o.addr, o.we, o.size, o.ri, o.rd, IRdataF, DRdataM);
        chk("vec_latency", 32'(o.lat), 32'd0);
        chk("vec_addr", o.addr, v.exp_addr);
        chk("vec_we", 32'(o.we), 32'(v.exp_we));
        chk("vec_size", 32'(o.size), 32'(v.exp_size));
        chk("vec_wdata", o.wdata, v.exp_wdata);
        chk("vec_ireadyf", 32'(o.ri), 32'(!v.exp_d));
        chk("vec_dreadym", 32'(o.rd), 32'(v.exp_d));
        chk("vec_irdataf", IRdataF, v.exp_irdata);
        chk("vec_drdatam", DRdataM, v.exp_drdata);
        drop_and_idle();
    endtask

    vec_t vecs[6];
    logic seq_ireq[18] = '{1,1,1,1,1,1,1,1,1,1, 1,1,0,1,1,1,1,1};
    logic seq_expd[18] = '{1,1,1,1,0,1,1,1,1,0, 1,1,1,1,1,1,1,0};

    initial begin
        obs_t o;
        //          ireq iaddr     dreq dwe daddr     dwdata        dsz   w  mrdata        d  addr      we sz    wdata         irdata        drdata
        vecs[0] = '{1, 32'h100,  0, 0, 32'h0,    32'h0,        3'b000, 0, 32'h00500093, 0, 32'h100,  0, 3'b010, 32'h0,        32'h00500093, 32'h0};
        vecs[1] = '{0, 32'h0,    1, 1, 32'h2000, 32'hDEADBEEF, 3'b000, 3, 32'hCAFEF00D, 1, 32'h2000, 1, 3'b000, 32'hDEADBEEF, 32'h00500093, 32'h0};
        vecs[2] = '{0, 32'h0,    1, 0, 32'h3004, 32'hAAAA5555, 3'b010, 1, 32'h12345678, 1, 32'h3004, 0, 3'b010, 32'hAAAA5555, 32'h00500093, 32'h12345678};
        vecs[3] = '{1, 32'h104,  0, 0, 32'h0,    32'h0,        3'b000, 2, 32'hFFFFFFFF, 0, 32'h104,  0, 3'b010, 32'h0,        32'hFFFFFFFF, 32'h12345678};
        vecs[4] = '{0, 32'h0,    1, 1, 32'h2004, 32'h0,        3'b001, 0, 32'hBAD0BAD0, 1, 32'h2004, 1, 3'b001, 32'h0,        32'hFFFFFFFF, 32'h12345678};
        vecs[5] = '{0, 32'h0,    1, 0, 32'h7,    32'h0,        3'b100, 0, 32'h000000AB, 1, 32'h7,    0, 3'b100, 32'h0,        32'hFFFFFFFF, 32'h000000AB};

        rst_n = 1'b0;
        IReqF = 1'b0; IAddrF = 32'h0;
        DReqM = 1'b0; DWeM = 1'b0; DAddrM = 32'h0; DWdataM = 32'h0; DSizeM = 3'b0;
        MemRdata = 32'h0; MemReady = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_memreq", 32'(MemReq), 32'd0);
        chk("rst_memwe", 32'(MemWe), 32'd0);
        chk("rst_memaddr", MemAddr, 32'h0);
        chk("rst_memwdata", MemWdata, 32'h0);
        chk("rst_memsize", 32'(MemSize), 32'd0);
        chk("rst_ready", 32'({IReadyF, DReadyM}), 32'd0);
        chk("rst_irdataf", IRdataF, 32'h0);
        chk("rst_drdatam", DRdataM, 32'h0);
        $display("reset: memreq=%0d ready=%0d%0d", MemReq, IReadyF, DReadyM);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Simultaneous requests: data first, then the waiting fetch.
        IReqF = 1'b1; IAddrF = 32'h200;
        DReqM = 1'b1; DWeM = 1'b0; DAddrM = 32'h400; DSizeM = 3'b010; DWdataM = 32'h0;
        serve(0, 32'h11111111, o);
        $display("both #1: addr=%h ri=%0d rd=%0d", o.addr, o.ri, o.rd);
        chk("both1_addr", o.addr, 32'h400);
        chk("both1_dready", 32'(o.rd), 32'd1);
        chk("both1_iready", 32'(o.ri), 32'd0);
        chk("both1_drdata", DRdataM, 32'h11111111);
        DReqM = 1'b0;
        serve(0, 32'h22222222, o);
        $display("both #2: addr=%h ri=%0d rd=%0d", o.addr, o.ri, o.rd);
        chk("both2_addr", o.addr, 32'h200);
        chk("both2_iready", 32'(o.ri), 32'd1);
        chk("both2_dready", 32'(o.rd), 32'd0);
        chk("both2_irdata", IRdataF, 32'h22222222);
        chk("both2_latency", 32'(o.lat), 32'd1);
        drop_and_idle();

        // Streak: held requests, new addresses each completion.
        DWeM = 1'b0; DSizeM = 3'b010;
        for (int k = 0; k < 18; k++) begin
            IReqF  = seq_ireq[k];
            IAddrF = 32'h8000 + 32'(k * 4);
            DReqM  = 1'b1;
            DAddrM = 32'h9000 + 32'(k * 4);
            serve(0, 32'(k), o);
            $display("streak step %0d: ireq=%0d addr=%h rd=%0d ri=%0d lat=%0d",
                     k, seq_ireq[k], o.addr, o.rd, o.ri, o.lat);
            chk("streak_grant_d", 32'(o.rd), 32'(seq_expd[k]));
            chk("streak_grant_i", 32'(o.ri), 32'(!seq_expd[k]));
            chk("streak_latency", 32'(o.lat), (k == 0) ? 32'd0 : 32'd1);
        end
        drop_and_idle();

        // Request inputs toggled during BUSY must not reach the memory port.
        perturb = 1'b1;
        DReqM = 1'b1; DWeM = 1'b1; DAddrM = 32'h5000; DWdataM = 32'h13579BDF; DSizeM = 3'b010;
        serve(3, 32'h0, o);
        perturb = 1'b0;
        $display("perturb: addr=%h wdata=%h rd=%0d", o.addr, o.wdata, o.rd);
        chk("perturb_addr", o.addr, 32'h5000);
        chk("perturb_wdata", o.wdata, 32'h13579BDF);
        chk("perturb_dready", 32'(o.rd), 32'd1);
        drop_and_idle();

        // Reset during BUSY: everything clears asynchronously, request retried.
        DReqM = 1'b1; DWeM = 1'b0; DAddrM = 32'h6000; DWdataM = 32'h0; DSizeM = 3'b010;
        @(posedge clk); @(negedge clk);
        chk("pre_rst_memreq", 32'(MemReq), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        $display("async reset: memreq=%0d addr=%h drdata=%h", MemReq, MemAddr, DRdataM);
        chk("arst_memreq", 32'(MemReq), 32'd0);
        chk("arst_memaddr", MemAddr, 32'h0);
        chk("arst_memsize", 32'(MemSize), 32'd0);
        chk("arst_ready", 32'({IReadyF, DReadyM}), 32'd0);
        chk("arst_irdataf", IRdataF, 32'h0);
        chk("arst_drdatam", DRdataM, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        serve(0, 32'h0BADF00D, o);
        $display("after reset: addr=%h rd=%0d drdata=%h lat=%0d", o.addr, o.rd, DRdataM, o.lat);
        chk("rearb_latency", 32'(o.lat), 32'd0);
        chk("rearb_addr", o.addr, 32'h6000);
        chk("rearb_dready", 32'(o.rd), 32'd1);
        chk("rearb_drdata", DRdataM, 32'h0BADF00D);
        drop_and_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
